// File: rtl/fletcher_arbiter_if.sv
// fletcher_arbiter_if: requester streams, engine recv/send channels and the
// tagged response port of fletcher_arbiter bundled into one interface.
// master = arbiter side, slave = requesters/engine/consumer side.
interface fletcher_arbiter_if #(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_val;
    logic [NREQ-1:0]    req_rdy;
    logic [16*NREQ-1:0] req_msg;
    logic [NREQ-1:0]    req_last;

    logic               eng_recv_val;
    logic               eng_recv_rdy;
    logic [15:0]        eng_recv_msg;
    logic               eng_recv_last;

    logic               eng_send_val;
    logic               eng_send_rdy;
    logic [31:0]        eng_send_msg;

    logic               resp_val;
    logic               resp_rdy;
    logic [31:0]        resp_msg;
    logic [IDW-1:0]     resp_id;

    modport master (
        input  req_val, req_msg, req_last,
        input  eng_recv_rdy, eng_send_val, eng_send_msg,
        input  resp_rdy,
        output req_rdy,
        output eng_recv_val, eng_recv_msg, eng_recv_last,
        output eng_send_rdy,
        output resp_val, resp_msg, resp_id
    );

    modport slave (
        output req_val, req_msg, req_last,
        output eng_recv_rdy, eng_send_val, eng_send_msg,
        output resp_rdy,
        input  req_rdy,
        input  eng_recv_val, eng_recv_msg, eng_recv_last,
        input  eng_send_rdy,
        input  resp_val, resp_msg, resp_id
    );
endinterface

// File: rtl/fletcher_arbiter.sv
// fletcher_arbiter: round-robin scheduler sharing one fletcher32 engine
// between NREQ framed 16-bit word streams. One frame in flight at a time:
// arbitrate (IDLE), pass the granted stream through (STREAM), collect the
// checksum (WAIT), hold the tagged response until consumed (RESP).
// Optional: define FLETCHER_ARB_STATS_EN to add the stat_frames/stat_stall
// counters and ports.
module fletcher_arbiter #(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    fletcher_arbiter_if.master bus
`ifdef FLETCHER_ARB_STATS_EN
    ,
    output logic [15:0]        stat_frames,
    output logic [15:0]        stat_stall
`endif
);
    localparam int          IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned N   = NREQ;

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;

    state_t         state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] ptr_q;
    logic [31:0]    resp_msg_q;
    logic [IDW-1:0] resp_id_q;

    logic [IDW-1:0] pick_d;
    logic           found_d;
    logic [IDW-1:0] ptr_d;
    logic           g_val;
    logic           g_last;
    logic [15:0]    g_msg;
    logic           word_fire;

    // Rotating priority search: first valid requester at ptr, ptr+1, ... mod NREQ
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        pick_d  = ptr_q;
        found_d = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            cand = IDW'(idx);
            if (!found_d && bus.req_val[cand]) begin
                found_d = 1'b1;
                pick_d  = cand;
            end
        end
    end

    // Next search start: one past the last grant, explicit wrap for any NREQ
    always_comb begin
        ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;
    end

    // Granted-stream pass-through to the engine while streaming
    always_comb begin
        g_val             = bus.req_val[grant_q];
        g_last            = bus.req_last[grant_q];
        g_msg             = bus.req_msg[16*grant_q +: 16];
        bus.req_rdy       = '0;
        bus.eng_recv_val  = 1'b0;
        bus.eng_recv_msg  = '0;
        bus.eng_recv_last = 1'b0;
        if (state_q == STREAM) begin
            bus.eng_recv_val     = g_val;
            bus.eng_recv_msg     = g_msg;
            bus.eng_recv_last    = g_last;
            bus.req_rdy[grant_q] = bus.eng_recv_rdy;
        end
    end

    assign word_fire    = (state_q == STREAM) && g_val && bus.eng_recv_rdy;
    assign bus.eng_send_rdy = (state_q == WAIT);
    assign bus.resp_val     = (state_q == RESP);
    assign bus.resp_msg     = resp_msg_q;
    assign bus.resp_id      = resp_id_q;

    // Frame scheduler: arbitration, streaming, checksum capture, response hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            resp_msg_q <= '0;
            resp_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= pick_d;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (word_fire && g_last) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_send_val) begin
                        resp_msg_q <= bus.eng_send_msg;
                        resp_id_q  <= grant_q;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_rdy) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FLETCHER_ARB_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] stall_q;

    // Completed-response and engine-stall counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (state_q == RESP && bus.resp_rdy) frames_q <= frames_q + 16'd1;
            if (state_q == STREAM && g_val && !bus.eng_recv_rdy) stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_frames = frames_q;
    assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_fletcher_arbiter.sv
// tb_fletcher_arbiter: frame-level scoreboard for fletcher_arbiter. Requester
// frames are queued per port, a behavioural engine computes fletcher32 of the
// words it receives, and responses are checked against checksums computed from
// the words the requesters sent, with round-robin ownership predicted from the
// queue contents and the rotating pointer rule.
module tb_fletcher_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fletcher_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef FLETCHER_ARB_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_stall;
`endif

    fletcher_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FLETCHER_ARB_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_stall  (stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] wq   [NREQ][$];
    int          flen [NREQ][$];
    int          pos  [NREQ];
    int          mptr, phase, cur_owner;
    logic [15:0] fr_words [$];
    logic [31:0] exp_msg_q [$];
    int          exp_id_q  [$];

    logic [15:0] eng_words [$];
    bit          eng_pend;
    int          eng_dly, eng_dly_max;
    logic [31:0] eng_chk;
    bit          ovr_en;
    logic [31:0] ovr_val;

    int          erdy_mode;
    bit          tog;
    int          resp_hold_cfg, hold_left;
    bit          resp_rand;
    bit          held;
    logic [31:0] held_msg;
    logic [IDW-1:0] held_id;
    int          stab_cnt;

    int          resp_count, stall_cnt, cyc, last_resp_cyc;
    int          rid_seq [$];
    int          gaps    [$];
    logic [31:0] last_msg;
    int          last_id;

    function automatic logic [31:0] fletcher(input logic [15:0] w [$]);
        int unsigned s1, s2;
        s1 = 0;
        s2 = 0;
        foreach (w[k]) begin
            s1 = (s1 + 32'(w[k])) % 65535;
            s2 = (s2 + s1) % 65535;
        end
        return {s2[15:0], s1[15:0]};
    endfunction

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (mptr + k) % NREQ;
            if (wq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.req_val      = '0;
        bus.req_last     = '0;
        bus.req_msg      = '0;
        bus.eng_recv_rdy = 1'b0;
        bus.eng_send_val = 1'b0;
        bus.eng_send_msg = '0;
        bus.resp_rdy     = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            wq[i].delete();
            flen[i].delete();
            pos[i] = 0;
        end
        phase = 0; mptr = 0; cur_owner = -1;
        fr_words.delete(); exp_msg_q.delete(); exp_id_q.delete();
        eng_words.delete(); eng_pend = 0; eng_dly = 0;
        held = 0; hold_left = resp_hold_cfg; stall_cnt = 0;
        last_resp_cyc = -100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic add_words(input int r, input logic [15:0] w [$]);
        foreach (w[k]) wq[r].push_back(w[k]);
        flen[r].push_back(w.size());
    endtask

    task automatic add_rand(input int r, input int n);
        logic [15:0] w [$];
        for (int k = 0; k < n; k++) w.push_back(16'($urandom));
        add_words(r, w);
    endtask

    // One clock: drive at negedge, observe 1 time unit before the posedge.
    task automatic run_cycle();
        int a;
        logic [NREQ-1:0] am, rfire;
        logic [15:0] w;
        bit lst, efire;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (wq[i].size() > 0) begin
                bus.req_val[i]          = 1'b1;
                bus.req_msg[16*i +: 16] = wq[i][0];
                bus.req_last[i]         = (pos[i] == flen[i][0] - 1);
            end else begin
                bus.req_val[i]          = 1'b0;
                bus.req_msg[16*i +: 16] = 16'($urandom);
                bus.req_last[i]         = 1'($urandom);
            end
        end
        case (erdy_mode)
            0: bus.eng_recv_rdy = 1'b1;
            1: bus.eng_recv_rdy = 1'($urandom_range(0, 1));
            2: begin tog = ~tog; bus.eng_recv_rdy = tog; end
            default: bus.eng_recv_rdy = 1'b0;
        endcase
        if (eng_pend && eng_dly == 0) begin
            bus.eng_send_val = 1'b1;
            bus.eng_send_msg = eng_chk;
        end else begin
            bus.eng_send_val = 1'b0;
            bus.eng_send_msg = 32'($urandom);
            if (eng_pend) eng_dly--;
        end
        if (bus.resp_val && hold_left > 0) begin
            bus.resp_rdy = 1'b0;
            hold_left--;
        end else begin
            bus.resp_rdy = resp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #4;
        cyc++;
        a  = (phase == 0) ? pick() : cur_owner;
        am = (a >= 0) ? NREQ'(1 << a) : '0;
        total++;
        if ((bus.req_rdy & ~am) !== '0) begin
            bad++;
            $display("FAIL req_rdy_owner: got %b allowed %b", bus.req_rdy, am);
        end
        rfire = bus.req_val & bus.req_rdy;
        efire = bus.eng_recv_val && bus.eng_recv_rdy;
        total++;
        if (efire !== (rfire != '0)) begin
            bad++;
            $display("FAIL fire_match: eng_fire %0b req_fire %b", efire, rfire);
        end
        if (bus.eng_recv_val && !bus.eng_recv_rdy) stall_cnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (rfire[i]) begin
                if (phase == 2) begin
                    total++; bad++;
                    $display("FAIL extra_word: requester %0d got word while checksum outstanding", i);
                end else begin
                    if (phase == 0) begin
                        total++;
                        if (i !== pick()) begin
                            bad++;
                            $display("FAIL grant: got %0d want %0d", i, pick());
                        end
                        gaps.push_back(cyc - last_resp_cyc);
                        cur_owner = i;
                        phase = 1;
                        fr_words.delete();
                    end else begin
                        total++;
                        if (i !== cur_owner) begin
                            bad++;
                            $display("FAIL owner: got %0d want %0d", i, cur_owner);
                        end
                    end
                    w   = wq[i].pop_front();
                    lst = (pos[i] == flen[i][0] - 1);
                    total++;
                    if (bus.eng_recv_msg !== w || bus.eng_recv_last !== lst) begin
                        bad++;
                        $display("FAIL eng_word: got %h/%0b want %h/%0b", bus.eng_recv_msg, bus.eng_recv_last, w, lst);
                    end
                    fr_words.push_back(w);
                    pos[i]++;
                    if (lst) begin
                        pos[i] = 0;
                        void'(flen[i].pop_front());
                        phase = 2;
                        exp_msg_q.push_back(ovr_en ? ovr_val : fletcher(fr_words));
                        exp_id_q.push_back(i);
                    end
                end
            end
        end
        if (efire) begin
            eng_words.push_back(bus.eng_recv_msg);
            if (bus.eng_recv_last) begin
                eng_chk  = ovr_en ? ovr_val : fletcher(eng_words);
                eng_words.delete();
                eng_pend = 1;
                eng_dly  = $urandom_range(0, eng_dly_max);
            end
        end
        if (bus.eng_send_val && bus.eng_send_rdy) eng_pend = 0;
        if (bus.resp_val) begin
            if (held) begin
                total++; stab_cnt++;
                if (bus.resp_msg !== held_msg || bus.resp_id !== held_id) begin
                    bad++;
                    $display("FAIL resp_stable: got %h/%0d want %h/%0d", bus.resp_msg, bus.resp_id, held_msg, held_id);
                end
            end
            if (bus.resp_rdy) begin
                total++;
                if (exp_id_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: got %h/%0d want none", bus.resp_msg, bus.resp_id);
                end else begin
                    if (bus.resp_msg !== exp_msg_q[0] || bus.resp_id !== IDW'(exp_id_q[0])) begin
                        bad++;
                        $display("FAIL resp: got %h/%0d want %h/%0d", bus.resp_msg, bus.resp_id, exp_msg_q[0], exp_id_q[0]);
                    end
                    mptr = (exp_id_q[0] + 1) % NREQ;
                    void'(exp_msg_q.pop_front());
                    void'(exp_id_q.pop_front());
                end
                rid_seq.push_back(int'(bus.resp_id));
                last_msg = bus.resp_msg;
                last_id  = int'(bus.resp_id);
                resp_count++;
                phase = 0;
                last_resp_cyc = cyc;
                held = 0;
                hold_left = resp_hold_cfg;
            end else begin
                held     = 1;
                held_msg = bus.resp_msg;
                held_id  = bus.resp_id;
            end
        end
    endtask

    task automatic run_frames(input int n, input int budget, output bit ok);
        int target;
        target = resp_count + n;
        for (int c = 0; c < budget && resp_count < target; c++) run_cycle();
        ok = (resp_count >= target);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        clear_model();
        #1;
        total++;
        if ({bus.resp_val, bus.eng_recv_val, bus.eng_send_rdy, bus.req_rdy} !== '0) begin
            bad++;
            $display("FAIL reset_vr: got rv=%0b erv=%0b esr=%0b rr=%b want all 0", bus.resp_val, bus.eng_recv_val, bus.eng_send_rdy, bus.req_rdy);
        end
        total++;
        if (bus.resp_msg !== 32'h0 || bus.resp_id !== '0) begin
            bad++;
            $display("FAIL reset_regs: got %h/%0d want 0/0", bus.resp_msg, bus.resp_id);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [15:0] f [$];
        bit ok;
        erdy_mode = 0; resp_rand = 0; resp_hold_cfg = 0; hold_left = 0; eng_dly_max = 1;
        f = '{16'h0001, 16'h0002};
        add_words(0, f);
        run_frames(1, 50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout: got %0d responses want 1", resp_count); end
        total++;
        if (last_msg !== 32'h0004_0003 || last_id !== 0) begin
            bad++;
            $display("FAIL single_resp: got %h/%0d want 00040003/0", last_msg, last_id);
        end
    endtask

    task automatic test_round_robin();
        int want [4] = '{0, 1, 0, 1};
        int base;
        bit ok;
        do_reset();
        erdy_mode = 0; resp_rand = 0; eng_dly_max = 2;
        base = rid_seq.size();
        gaps.delete();
        for (int k = 0; k < 2; k++) begin
            add_rand(0, 3);
            add_rand(1, 3);
        end
        run_frames(4, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d responses", rid_seq.size() - base); end
        for (int k = 0; k < 4 && base + k < rid_seq.size(); k++) begin
            total++;
            if (rid_seq[base + k] !== want[k]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, rid_seq[base + k], want[k]);
            end
        end
        for (int k = 1; k < gaps.size(); k++) begin
            total++;
            if (gaps[k] !== 2) begin
                bad++;
                $display("FAIL rr_bubble[%0d]: got %0d cycles resp->first word want 2", k, gaps[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int s0;
        bit ok;
        erdy_mode = 2; resp_rand = 0; resp_hold_cfg = 5; hold_left = 5; eng_dly_max = 2;
        s0 = stab_cnt;
        add_rand(0, 5);
        add_rand(1, 4);
        run_frames(2, 300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout: got %0d responses", resp_count); end
        total++;
        if (stab_cnt - s0 !== 10) begin
            bad++;
            $display("FAIL bp_hold_cycles: got %0d stable checks want 10", stab_cnt - s0);
        end
        resp_hold_cfg = 0; hold_left = 0;
    endtask

    task automatic test_one_word();
        logic [15:0] f [$];
        int n;
        bit ok;
        erdy_mode = 0; resp_rand = 0; eng_dly_max = 1;
        ovr_en = 1; ovr_val = 32'hFFFF_FFFF;
        f = '{16'hFFFF};
        add_words(1, f);
        run_frames(1, 50, ok);
        ovr_en = 0;
        total++;
        if (!ok || last_msg !== 32'hFFFF_FFFF || last_id !== 1) begin
            bad++;
            $display("FAIL one_word: got %h/%0d ok=%0b want ffffffff/1", last_msg, last_id, ok);
        end
        add_rand(1, 2);
        add_rand(0, 2);
        run_frames(2, 100, ok);
        n = rid_seq.size();
        total++;
        if (!ok || rid_seq[n-2] !== 0 || rid_seq[n-1] !== 1) begin
            bad++;
            $display("FAIL wrap_to_0: got %0d,%0d ok=%0b want 0,1", rid_seq[n-2], rid_seq[n-1], ok);
        end
    endtask

    task automatic test_random();
        bit ok;
        erdy_mode = 1; resp_rand = 1; eng_dly_max = 3;
        for (int k = 0; k < 30; k++) add_rand($urandom_range(0, NREQ - 1), $urandom_range(1, 6));
        run_frames(30, 4000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rand_timeout: got %0d responses", resp_count); end
        total++;
        if (wq[0].size() + wq[1].size() + exp_id_q.size() !== 0) begin
            bad++;
            $display("FAIL rand_drain: got %0d words/%0d resp left want 0", wq[0].size() + wq[1].size(), exp_id_q.size());
        end
        resp_rand = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        erdy_mode = 0; resp_rand = 0; eng_dly_max = 1;
        add_rand(0, 4);
        for (int c = 0; c < 50 && pos[0] < 2; c++) run_cycle();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({bus.resp_val, bus.eng_recv_val, bus.eng_send_rdy, bus.req_rdy} !== '0 ||
            bus.resp_msg !== 32'h0 || bus.resp_id !== '0) begin
            bad++;
            $display("FAIL mid_reset_out: got erv=%0b rr=%b rv=%0b msg=%h want all 0", bus.eng_recv_val, bus.req_rdy, bus.resp_val, bus.resp_msg);
        end
        clear_inputs();
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        add_rand(1, 3);
        run_frames(1, 50, ok);
        total++;
        if (!ok || last_id !== 1) begin
            bad++;
            $display("FAIL mid_reset_after: got id %0d ok=%0b want 1", last_id, ok);
        end
        for (int c = 0; c < 4; c++) run_cycle();
        total++;
        if (resp_count !== rid_seq.size() || exp_id_q.size() !== 0) begin
            bad++;
            $display("FAIL mid_reset_ghost: got %0d pending want 0", exp_id_q.size());
        end
    endtask

`ifdef FLETCHER_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        do_reset();
        erdy_mode = 0; resp_rand = 0; eng_dly_max = 2;
        add_rand(0, 2);
        add_rand(1, 2);
        add_rand(0, 2);
        run_frames(3, 100, ok);
        @(posedge clk); #1;
        total++;
        if (!ok || stat_frames !== 16'd3) begin
            bad++;
            $display("FAIL stat_frames: got %0d want 3", stat_frames);
        end
        add_rand(0, 3);
        erdy_mode = 3;
        for (int c = 0; c < 5; c++) run_cycle();
        @(posedge clk); #1;
        total++;
        if (stat_stall !== 16'd4) begin
            bad++;
            $display("FAIL stat_stall: got %0d want 4", stat_stall);
        end
        erdy_mode = 0;
        run_frames(1, 50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stat_drain: got timeout want response"); end
    endtask
`endif

    initial begin
        cyc = 0; resp_count = 0; stab_cnt = 0; tog = 0;
        ovr_en = 0; ovr_val = '0; eng_dly_max = 1; erdy_mode = 0;
        resp_hold_cfg = 0; resp_rand = 0; last_msg = '0; last_id = -1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_back_pressure();
        test_one_word();
        test_random();
        test_reset_mid();
`ifdef FLETCHER_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fletcher_arbiter.md
Name: fletcher_arbiter

Overview:
Round-robin scheduler sharing one fletcher32 checksum engine between NREQ framed 16-bit word streams.
- Grants one requester per frame and streams that frame's words to the engine.
- Waits for the engine's 32-bit checksum and returns it on a single response port, tagged with the requester id.
- Sits between the requester val/rdy streams and the engine's recv/send val/rdy ports.

Parameters:
NREQ, 2, number of requesters (1..8)
IDW, localparam, $clog2(NREQ), minimum 1; width of resp_id

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_val  input  NREQ  per-requester word valid
req_rdy  output  NREQ  per-requester word ready
req_msg  input  16*NREQ  per-requester data word; requester i uses bits [16i+15:16i]
req_last  input  NREQ  marks the final word of a frame
eng_recv_val  output  1  word valid to engine
eng_recv_rdy  input  1  engine ready for a word
eng_recv_msg  output  16  word to engine
eng_recv_last  output  1  final word of frame to engine
eng_send_val  input  1  engine checksum valid
eng_send_rdy  output  1  arbiter ready for checksum
eng_send_msg  input  32  engine checksum
resp_val  output  1  response valid
resp_rdy  input  1  consumer ready
resp_msg  output  32  checksum
resp_id  output  IDW  requester index that owns resp_msg

Behaviour:
- State machine states: IDLE, STREAM, WAIT, RESP.
- Registers: state, grant (IDW bits), ptr (IDW bits), resp_msg, resp_id.
- Reset (reset=0, asynchronous assertion):
  - state=IDLE, grant=0, ptr=0, resp_msg=0, resp_id=0.
  - All val/rdy outputs are 0.
  - Reset mid-frame abandons the frame; no response is produced for it.
- IDLE:
  - All req_rdy=0, eng_recv_val=0, eng_send_rdy=0, resp_val=0.
  - If any req_val is 1: grant <= first index i with req_val[i]=1, searching ptr, ptr+1, ... modulo NREQ; next state STREAM.
  - Arbitration costs exactly one bubble cycle per frame.
- STREAM: combinational pass-through of the granted requester g.
  - eng_recv_val=req_val[g], eng_recv_msg=req_msg[g], eng_recv_last=req_last[g].
  - req_rdy[g]=eng_recv_rdy; req_rdy of every other requester is 0.
  - When eng_recv_val and eng_recv_rdy are both 1 and req_last[g]=1: next state WAIT.
  - Frame length is unbounded; a 1-word frame (last on the first word) is legal.
  - req_val changes on non-granted ports have no effect.
- WAIT:
  - eng_send_rdy=1 only in this state; the engine is back-pressured in every other state.
  - On eng_send_val=1: resp_msg <= eng_send_msg, resp_id <= grant; next state RESP.
- RESP:
  - resp_val=1, driven from registers; resp_msg and resp_id are stable while resp_val=1 and resp_rdy=0.
  - On resp_rdy=1: ptr <= (grant+1) mod NREQ; next state IDLE.
- Latency: response valid 1 cycle after the engine checksum handshake.
- Minimum per-frame overhead, with all handshakes ready: 1 arbitration cycle + 1 RESP cycle, plus engine latency.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 frames.
- Arithmetic: ptr and grant wrap from NREQ-1 to 0; NREQ that is not a power of two must wrap explicitly, never via bit overflow.
- Only one frame is in flight; a new grant never overlaps an outstanding checksum.

Optional Feature:
FLETCHER_ARB_STATS_EN
- Defined:
  - Adds output port stat_frames, 16 bits: count of completed responses (RESP with resp_rdy=1).
  - Adds output port stat_stall, 16 bits: count of cycles in STREAM with eng_recv_val=1 and eng_recv_rdy=0.
  - Both counters reset to 0 and wrap 0xFFFF->0x0000.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Single frame: requester 0 sends 0x0001, 0x0002 (last); engine returns 0x00040003 -> resp_msg=0x00040003, resp_id=0; requester 1 sees req_rdy=0 throughout.
- Round-robin: NREQ=2, both requesters continuously valid with 3-word frames -> resp_id sequence 0,1,0,1; there is exactly one IDLE cycle between RESP and STREAM.
- Back-pressure: eng_recv_rdy toggles every cycle and resp_rdy is held 0 for 5 cycles -> no word lost or duplicated; resp_msg/resp_id are stable for all 5 cycles.
- 1-word frame: requester 1 sends 0xFFFF with last=1; engine returns 0xFFFFFFFF -> resp_msg=0xFFFFFFFF, resp_id=1; next grant search starts at index 0.
- Reset mid-frame: reset is asserted after the 2nd word of a 4-word frame -> all outputs 0 immediately; after release, a new frame from requester 1 is granted first-come (ptr=0 search) and completes normally.
- With FLETCHER_ARB_STATS_EN: 3 frames complete -> stat_frames=3; hold eng_recv_rdy=0 for 4 STREAM cycles -> stat_stall=4.
